pg_burst_sched: RTL and testbench

- Burst scheduler and sequencer for the pulse generator output path.
- Latches a burst configuration (high time, low time, pulse count, inter-burst gap, repeat mode) on a start request.
- Sequences `signal_out` and `signal_cycle` through a timed state machine, using a tick enable, so the UI and seven-segment logic only write configuration and issue start/stop.
- Sits between the button/UI front end and the `ja0`/`ja1` outputs. `tick` comes from the turbosim-aware prescaler.

---
 rtl/pg_burst_sched.sv | 165 ++++++++++++++++
 tb/tb_pg_burst_sched.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pg_burst_sched.sv
// pg_burst_sched: burst scheduler / sequencer for the pulse generator output path.
//
// A start request latches a burst configuration, then a tick-gated FSM plays out
// cfg_num pulses of cfg_high ticks high and cfg_low ticks low, optionally
// repeating with a cfg_gap-tick idle gap between bursts. The UI only writes the
// configuration and issues start/stop.
//
// Ports:
//   clk          system clock
//   reset        asynchronous active-low reset
//   tick         timing enable; duration counters only advance when tick=1
//   start        single-cycle start request (accepted only when idle)
//   stop         single-cycle abort request
//   cfg_high     high time per pulse in ticks (0 behaves as 1)
//   cfg_low      low time per pulse in ticks (0 skips the low phase)
//   cfg_num      pulses per burst (0 makes start a no-op)
//   cfg_gap      idle ticks between bursts in repeat mode
//   cfg_repeat   1 = continuous bursts, 0 = single burst
//   signal_out   pulse train, high exactly while in HIGH
//   signal_cycle one-clock marker at the first clock of each burst
//   busy         high in every state except IDLE
//   pulse_num    0-based index of the current pulse
//   done         one-clock strobe on normal completion of a single burst
//   fsm_state    IDLE=0, HIGH=1, LOW=2, GAP=3, DONE=4

module pg_burst_sched #(
    parameter int unsigned CW = 16,
    parameter int unsigned NW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          tick,
    input  logic          start,
    input  logic          stop,
    input  logic [CW-1:0] cfg_high,
    input  logic [CW-1:0] cfg_low,
    input  logic [NW-1:0] cfg_num,
    input  logic [CW-1:0] cfg_gap,
    input  logic          cfg_repeat,
    output logic          signal_out,
    output logic          signal_cycle,
    output logic          busy,
    output logic [NW-1:0] pulse_num,
    output logic          done,
    output logic [2:0]    fsm_state
);

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StHigh = 3'd1,
        StLow  = 3'd2,
        StGap  = 3'd3,
        StDone = 3'd4
    } state_e;

    state_e        state_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] high_q;
    logic [CW-1:0] low_q;
    logic [CW-1:0] gap_q;
    logic [NW-1:0] num_q;
    logic          repeat_q;

    // Counter reload for HIGH; a zero high time still lasts one tick.
    logic [CW-1:0] high_load;
    logic [CW-1:0] start_load;
    assign high_load  = (high_q == '0) ? '0 : high_q - CW'(1);
    assign start_load = (cfg_high == '0) ? '0 : cfg_high - CW'(1);

    // End-of-pulse decision, shared by the HIGH (no low phase) and LOW exits.
    logic          last_pulse;
    state_e        eop_state;
    logic [CW-1:0] eop_cnt;
    logic [NW-1:0] eop_pulse;
    logic          eop_cycle;
    logic          eop_done;

    assign last_pulse = (pulse_num >= num_q - NW'(1));

    always_comb begin
        eop_state = StHigh;
        eop_cnt   = high_load;
        eop_pulse = pulse_num;
        eop_cycle = 1'b0;
        eop_done  = 1'b0;
        if (!last_pulse) begin
            eop_pulse = pulse_num + NW'(1);
        end else if (!repeat_q) begin
            eop_state = StDone;
            eop_cnt   = '0;
            eop_done  = 1'b1;
        end else if (gap_q != '0) begin
            eop_state = StGap;
            eop_cnt   = gap_q - CW'(1);
        end else begin
            // Back-to-back bursts: restart the pulse index and mark the new burst.
            eop_pulse = '0;
            eop_cycle = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            high_q       <= '0;
            low_q        <= '0;
            gap_q        <= '0;
            num_q        <= '0;
            repeat_q     <= 1'b0;
            signal_out   <= 1'b0;
            signal_cycle <= 1'b0;
            busy         <= 1'b0;
            pulse_num    <= '0;
            done         <= 1'b0;
        end else begin
            signal_cycle <= 1'b0;
            done         <= 1'b0;
            if (state_q == StIdle) begin
                if (start && !stop && (cfg_num != '0)) begin
                    high_q       <= cfg_high;
                    low_q        <= cfg_low;
                    gap_q        <= cfg_gap;
                    num_q        <= cfg_num;
                    repeat_q     <= cfg_repeat;
                    cnt_q        <= start_load;
                    pulse_num    <= '0;
                    state_q      <= StHigh;
                    signal_out   <= 1'b1;
                    signal_cycle <= 1'b1;
                    busy         <= 1'b1;
                end
            end else if (stop || (state_q == StDone)) begin
                // Abort or end of DONE; pulse_num keeps its last value.
                state_q    <= StIdle;
                signal_out <= 1'b0;
                busy       <= 1'b0;
            end else if (tick) begin
                if (cnt_q != '0) begin
                    cnt_q <= cnt_q - CW'(1);
                end else if ((state_q == StHigh) && (low_q != '0)) begin
                    state_q    <= StLow;
                    cnt_q      <= low_q - CW'(1);
                    signal_out <= 1'b0;
                end else if (state_q == StGap) begin
                    state_q      <= StHigh;
                    cnt_q        <= high_load;
                    pulse_num    <= '0;
                    signal_out   <= 1'b1;
                    signal_cycle <= 1'b1;
                end else begin
                    state_q      <= eop_state;
                    cnt_q        <= eop_cnt;
                    pulse_num    <= eop_pulse;
                    signal_out   <= (eop_state == StHigh);
                    signal_cycle <= eop_cycle;
                    done         <= eop_done;
                end
            end
        end
    end

    assign fsm_state = state_q;

endmodule

// File: tb/tb_pg_burst_sched.sv
// Self-checking bench for pg_burst_sched: directed scenarios followed by random
// traffic, all compared every clock against a tick-counting reference model.

module tb_pg_burst_sched;

    localparam int CW = 16;
    localparam int NW = 8;

    localparam int PIdle = 0;
    localparam int PHigh = 1;
    localparam int PLow  = 2;
    localparam int PGap  = 3;
    localparam int PDone = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          tick = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic [CW-1:0] cfg_high = '0;
    logic [CW-1:0] cfg_low = '0;
    logic [NW-1:0] cfg_num = '0;
    logic [CW-1:0] cfg_gap = '0;
    logic          cfg_repeat = 1'b0;
    logic          signal_out;
    logic          signal_cycle;
    logic          busy;
    logic [NW-1:0] pulse_num;
    logic          done;
    logic [2:0]    fsm_state;

    int checks = 0;
    int errors = 0;

    // Reference model: phase, ticks spent in phase, pulse index, latched config.
    int m_phase, m_ticks, m_pulse;
    int m_high, m_low, m_num, m_gap;
    bit m_rep, m_cycle, m_done;

    pg_burst_sched #(.CW(CW), .NW(NW)) dut (
        .clk          (clk),
        .reset        (reset),
        .tick         (tick),
        .start        (start),
        .stop         (stop),
        .cfg_high     (cfg_high),
        .cfg_low      (cfg_low),
        .cfg_num      (cfg_num),
        .cfg_gap      (cfg_gap),
        .cfg_repeat   (cfg_repeat),
        .signal_out   (signal_out),
        .signal_cycle (signal_cycle),
        .busy         (busy),
        .pulse_num    (pulse_num),
        .done         (done),
        .fsm_state    (fsm_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int phase_len(input int p);
        case (p)
            PHigh:   return (m_high == 0) ? 1 : m_high;
            PLow:    return m_low;
            default: return m_gap;
        endcase
    endfunction

    task automatic model_reset();
        m_phase = PIdle; m_ticks = 0; m_pulse = 0;
        m_high = 0; m_low = 0; m_num = 0; m_gap = 0;
        m_rep = 0; m_cycle = 0; m_done = 0;
    endtask

    task automatic enter(input int p);
        m_phase = p;
        m_ticks = 0;
    endtask

    // One clock of the model, using the inputs the DUT sees at this edge.
    task automatic model_step();
        m_cycle = 0;
        m_done  = 0;
        if (m_phase == PIdle) begin
            if (start && !stop && cfg_num != 0) begin
                m_high = int'(cfg_high); m_low = int'(cfg_low);
                m_num = int'(cfg_num); m_gap = int'(cfg_gap); m_rep = cfg_repeat;
                m_pulse = 0; m_cycle = 1;
                enter(PHigh);
            end
        end else if (stop || m_phase == PDone) begin
            m_phase = PIdle;
        end else if (tick) begin
            m_ticks++;
            if (m_ticks == phase_len(m_phase)) begin
                if (m_phase == PGap) begin
                    m_pulse = 0; m_cycle = 1; enter(PHigh);
                end else if (m_phase == PHigh && m_low != 0) begin
                    enter(PLow);
                end else if (m_pulse < m_num - 1) begin
                    m_pulse++; enter(PHigh);
                end else if (!m_rep) begin
                    m_phase = PDone; m_done = 1;
                end else if (m_gap != 0) begin
                    enter(PGap);
                end else begin
                    m_pulse = 0; m_cycle = 1; enter(PHigh);
                end
            end
        end
    endtask

    task automatic check_all();
        check("signal_out", 32'(signal_out), 32'(m_phase == PHigh));
        check("signal_cycle", 32'(signal_cycle), 32'(m_cycle));
        check("busy", 32'(busy), 32'(m_phase != PIdle));
        check("pulse_num", 32'(pulse_num), 32'(m_pulse));
        check("done", 32'(done), 32'(m_done));
        check("fsm_state", 32'(fsm_state), 32'(m_phase));
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic set_cfg(input int h, input int l, input int n, input int g, input bit r);
        cfg_high = CW'(h); cfg_low = CW'(l); cfg_num = NW'(n); cfg_gap = CW'(g);
        cfg_repeat = r;
    endtask

    initial begin
        logic [8:1] pat;
        int hi_cnt;
        int done_at;

        // Reset state.
        model_reset();
        @(negedge clk);
        check_all();
        reset = 1'b1;
        step();
        step();

        // Single burst: high 3, low 2, two pulses.
        tick = 1'b1;
        set_cfg(3, 2, 2, 0, 0);
        start = 1'b1; step(); start = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            check("t1_out", 32'(signal_out), 32'((k >= 1 && k <= 3) || (k >= 6 && k <= 8)));
            check("t1_cycle", 32'(signal_cycle), 32'(k == 1));
            check("t1_done", 32'(done), 32'(k == 11));
            if (k >= 6 && k <= 10) check("t1_pnum", 32'(pulse_num), 32'd1);
            if (k == 12) check("t1_busy", 32'(busy), 32'd0);
            step();
        end

        // Repeat mode with a 3-tick gap.
        set_cfg(1, 1, 2, 3, 1);
        pat = 8'b1000_0101;
        start = 1'b1; step(); start = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            if (k <= 8) check("t2_out", 32'(signal_out), 32'(pat[k]));
            check("t2_cycle", 32'(signal_cycle), 32'(k == 1 || k == 8));
            check("t2_done", 32'(done), 32'd0);
            step();
        end
        stop = 1'b1; step(); stop = 1'b0;
        step();

        // Tick every 4th clock, config rewritten mid-burst.
        set_cfg(2, 1, 1, 0, 0);
        hi_cnt = 0;
        done_at = -1;
        for (int k = 0; k < 16; k++) begin
            tick  = (k % 4 == 3);
            start = (k == 0);
            if (k == 2) set_cfg(9, 5, 4, 2, 1);
            step();
            if (signal_out) hi_cnt++;
            if (done) done_at = k + 1;
        end
        start = 1'b0;
        tick  = 1'b1;
        check("t3_high_clocks", 32'(hi_cnt), 32'd7);
        check("t3_done_cycle", 32'(done_at), 32'd12);

        // cfg_num = 0 is ignored.
        set_cfg(2, 2, 0, 0, 0);
        start = 1'b1; step(); start = 1'b0;
        check("t4_busy", 32'(busy), 32'd0);
        step();

        // Zero high/low times: three back-to-back single-clock pulses.
        set_cfg(0, 0, 3, 0, 0);
        start = 1'b1; step(); start = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            if (k <= 3) begin
                check("t5_pnum", 32'(pulse_num), 32'(k - 1));
                check("t5_out", 32'(signal_out), 32'd1);
            end
            check("t5_done", 32'(done), 32'(k == 4));
            step();
        end

        // Abort during LOW of pulse 1.
        set_cfg(2, 3, 3, 0, 0);
        start = 1'b1; step(); start = 1'b0;
        for (int k = 1; k < 9; k++) step();
        check("t6_low_state", 32'(fsm_state), 32'd2);
        stop = 1'b1; step(); stop = 1'b0;
        check("t6_abort_busy", 32'(busy), 32'd0);
        check("t6_abort_out", 32'(signal_out), 32'd0);
        check("t6_abort_pnum", 32'(pulse_num), 32'd1);
        start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
        check("t6_start_stop_idle", 32'(busy), 32'd0);
        set_cfg(1, 1, 2, 0, 0);
        start = 1'b1; step(); start = 1'b0;
        step();
        set_cfg(6, 6, 5, 0, 1);
        start = 1'b1; step(); start = 1'b0;
        for (int k = 0; k < 8; k++) step();

        // Asynchronous reset in the middle of HIGH.
        set_cfg(5, 1, 2, 0, 0);
        start = 1'b1; step(); start = 1'b0;
        step();
        #2 reset = 1'b0;
        #1;
        check("t7_rst_out", 32'(signal_out), 32'd0);
        check("t7_rst_busy", 32'(busy), 32'd0);
        check("t7_rst_state", 32'(fsm_state), 32'd0);
        check("t7_rst_pnum", 32'(pulse_num), 32'd0);
        model_reset();
        step();
        step();
        reset = 1'b1;
        for (int k = 0; k < 4; k++) step();

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            tick  = ($urandom % 10) < 7;
            start = ($urandom % 8) == 0;
            stop  = ($urandom % 30) == 0;
            set_cfg($urandom_range(0, 4), $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 3), 1'($urandom % 2));
            if (($urandom % 500) == 0) begin
                #3 reset = 1'b0;
                #1;
                model_reset();
                check_all();
                start = 1'b0;
                stop  = 1'b0;
                step();
                reset = 1'b1;
            end
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
